serial_word_tx: RTL and testbench

- Parallel-to-serial transmitter for the serial data highway. It is the sending end of the digit-timed serial interface that control-section blocks such as ccu_1 consume.
- Accepts one 36-bit long word or 18-bit short word through a valid/ready load port.
- Shifts the word out LSB first, one digit per clk, aligned to the one-hot digit pulses from digit_pulse_generator.
- Sits between store/arithmetic parallel registers and serial consumers. Used as a stimulus source in control-section benches.

---
 rtl/edsac_pkg.sv | 16 +
 rtl/digit_match.sv | 28 ++
 rtl/serial_word_tx.sv | 100 ++++++++++
 tb/tb_serial_word_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/edsac_pkg.sv
// Shared constants and state encoding for the serial data highway blocks.
package edsac_pkg;

    localparam int WORD_DIGITS  = 36;
    localparam int SHORT_DIGITS = 18;
    localparam int LAST_DIGIT   = 35;
    localparam int HALF_START   = 18;
    localparam int DIGIT_W      = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/digit_match.sv
// Picks the trigger and last digit pulses for the latched window and
// checks that the digit pulse vector is one-hot.
module digit_match
    import edsac_pkg::*;
(
    input  logic [WORD_DIGITS-1:0] d,
    input  logic [DIGIT_W-1:0]     start_digit,
    input  logic [DIGIT_W-1:0]     last_digit,
    output logic                   trigger,
    output logic                   last_hit,
    output logic                   one_hot
);

    logic [DIGIT_W-1:0] trig_digit;

    // The trigger is the digit just before the window start, wrapping d0 back to d35.
    always_comb begin
        trig_digit = start_digit - DIGIT_W'(1);
        if (start_digit == '0) begin
            trig_digit = DIGIT_W'(LAST_DIGIT);
        end
    end

    assign trigger  = d[trig_digit];
    assign last_hit = d[last_digit];
    assign one_hot  = $onehot(d);

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: loads a long or short word and shifts
// it out LSB first, one digit per clock, aligned to the digit pulses.
module serial_word_tx #(
    parameter int WORD_DIGITS  = 36,
    parameter int SHORT_DIGITS = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_DIGITS-1:0] d,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WORD_DIGITS-1:0] load_data,
    input  logic                   load_long,
    input  logic                   load_half,
    output logic                   ser_out,
    output logic                   busy,
    output logic                   done,
    output logic                   sync_err
);

    import edsac_pkg::*;

    tx_state_t              state;
    tx_state_t              state_nx;
    logic [WORD_DIGITS-1:0] shreg;
    logic [DIGIT_W-1:0]     start_q;
    logic [DIGIT_W-1:0]     last_q;
    logic                   done_q;
    logic                   sync_q;
    logic                   trigger;
    logic                   last_hit;
    logic                   one_hot;
    logic                   accept;

    digit_match u_match (
        .d           (d),
        .start_digit (start_q),
        .last_digit  (last_q),
        .trigger     (trigger),
        .last_hit    (last_hit),
        .one_hot     (one_hot)
    );

    // A load transfers on a rising edge where load_valid and load_ready are both high;
    // load_ready is high only in IDLE, so a new word can be taken in the done cycle.
    assign load_ready = (state == IDLE);
    assign accept     = load_valid & load_ready;
    assign busy       = (state != IDLE);
    assign ser_out    = (state == SHIFT) & shreg[0];
    assign done       = done_q;
    assign sync_err   = sync_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)   state_nx = ARMED;
            ARMED:   if (trigger)  state_nx = SHIFT;
            SHIFT:   if (last_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            start_q <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            done_q <= (state == SHIFT) && last_hit;
            if (busy && !one_hot) begin
                sync_q <= 1'b1;
            end
            if (accept) begin
                if (load_long) begin
                    shreg   <= load_data;
                    start_q <= '0;
                    last_q  <= DIGIT_W'(LAST_DIGIT);
                end else begin
                    // Short words sit in the low bits; the window start selects the half.
                    shreg   <= {{(WORD_DIGITS-SHORT_DIGITS){1'b0}}, load_data[SHORT_DIGITS-1:0]};
                    start_q <= load_half ? DIGIT_W'(HALF_START) : '0;
                    last_q  <= load_half ? DIGIT_W'(LAST_DIGIT) : DIGIT_W'(SHORT_DIGITS-1);
                end
            end else if (state == SHIFT) begin
                shreg <= {1'b0, shreg[WORD_DIGITS-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: directed vector table, hand-written
// corner sequences and randomized loads against a cycle schedule model.
module tb_serial_word_tx;

    logic        clk;
    logic        rst_n;
    logic [35:0] d;
    logic        load_valid;
    logic        load_ready;
    logic [35:0] load_data;
    logic        load_long;
    logic        load_half;
    logic        ser_out;
    logic        busy;
    logic        done;
    logic        sync_err;

    serial_word_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_long  (load_long),
        .load_half  (load_half),
        .ser_out    (ser_out),
        .busy       (busy),
        .done       (done),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] data;
        logic        lng;
        logic        half;
        int          acc_dig;
        int          exp_done;
        int          exp_ones;
    } vec_t;

    // Expected per-cycle outputs {ser_out, busy, done}, one entry per clock.
    logic [2:0]  exp_q[$];
    logic [2:0]  cur;
    logic        exp_sync;
    logic [35:0] one;
    int          dig;
    int          n_tests;
    int          n_fail;
    vec_t        vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
        end
    endtask

    // Window starts at digit S; the first bit appears at the first d[S] that is
    // at least two clocks after the accepting edge.
    task automatic model_accept(input int a, input logic [35:0] data, input logic lng, input logic half);
        int s;
        int n;
        int k;
        logic [35:0] w;
        n = lng ? 36 : 18;
        s = (!lng && half) ? 18 : 0;
        w = lng ? data : {18'd0, data[17:0]};
        k = (((s - a - 2) % 36) + 36) % 36 + 2;
        for (int i = 1; i < k; i++) exp_q.push_back(3'b010);
        for (int i = 0; i < n; i++) exp_q.push_back({w[i], 2'b10});
        exp_q.push_back(3'b001);
    endtask

    task automatic cycle();
        if (load_valid && !cur[1]) model_accept(dig, load_data, load_long, load_half);
        if (cur[1] && ($countones(d) != 1)) exp_sync = 1'b1;
        @(posedge clk);
        #1;
        dig = (dig == 35) ? 0 : dig + 1;
        d = one << dig;
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        check($sformatf("cycle_d%0d", dig),
              64'({ser_out, busy, done, load_ready, sync_err}),
              64'({cur[2], cur[1], cur[0], ~cur[1], exp_sync}));
    endtask

    task automatic wait_dig(input int target);
        int g;
        g = 0;
        while (dig != target && g < 80) begin
            cycle();
            g++;
        end
        check("wait_dig", 64'(dig), 64'(target));
    endtask

    task automatic wait_done(input string name);
        int g;
        g = 0;
        while (!done && g < 120) begin
            cycle();
            g++;
        end
        check(name, 64'(done), 64'(1));
    endtask

    task automatic run_vec(input int idx);
        int lat;
        int ones;
        vec_t v;
        v = vecs[idx];
        wait_dig(v.acc_dig);
        load_valid = 1'b1;
        load_data  = v.data;
        load_long  = v.lng;
        load_half  = v.half;
        cycle();
        load_valid = 1'b0;
        load_data  = {4'($urandom_range(0, 15)), 32'($urandom())};
        load_long  = 1'($urandom_range(0, 1));
        load_half  = 1'($urandom_range(0, 1));
        lat  = 1;
        ones = 0;
        while (!done && lat < 120) begin
            ones += int'(ser_out);
            cycle();
            lat++;
        end
        check($sformatf("vec%0d_done_latency", idx), 64'(lat), 64'(v.exp_done));
        check($sformatf("vec%0d_ones", idx), 64'(ones), 64'(v.exp_ones));
    endtask

    initial begin
        int ones;
        int ndone;
        int g;
        vecs[0] = '{36'h0_0000_0005, 1'b1, 1'b0, 10, 62, 2};
        vecs[1] = '{36'h0_0002_0001, 1'b0, 1'b1,  5, 31, 2};
        vecs[2] = '{36'h8_0000_0001, 1'b1, 1'b0, 35, 73, 2};
        vecs[3] = '{36'hF_FFFF_FFFF, 1'b0, 1'b0, 20, 34, 18};
        vecs[4] = '{36'h0_0000_0F0F, 1'b0, 1'b1, 16, 20, 8};
        vecs[5] = '{36'hF_FFFC_0000, 1'b0, 1'b0,  0, 54, 0};
        vecs[6] = '{36'h0_0001_2345, 1'b0, 1'b1, 17, 55, 7};

        n_tests    = 0;
        n_fail     = 0;
        one        = 36'd1;
        dig        = 0;
        d          = one;
        cur        = 3'b000;
        exp_sync   = 1'b0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_long  = 1'b0;
        load_half  = 1'b0;
        #2;
        check("reset_state", 64'({ser_out, busy, done, load_ready, sync_err}), 64'(5'b00010));
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3; i++) run_vec(i);

        // Digit pulses vanish for one clock while ARMED.
        wait_dig(20);
        load_valid = 1'b1;
        load_data  = 36'h0_F0F0_F0F0;
        load_long  = 1'b1;
        cycle();
        load_valid = 1'b0;
        wait_dig(25);
        d = '0;
        cycle();
        wait_done("sync_done");
        check("sync_sticky", 64'(sync_err), 64'(1));

        // load_valid held across two transfers.
        wait_dig(0);
        load_valid = 1'b1;
        load_data  = 36'hF_FFFF_FFFF;
        load_long  = 1'b1;
        cycle();
        load_data = 36'h0;
        ones  = 0;
        ndone = 0;
        g     = 0;
        while (ndone < 2 && g < 200) begin
            ones += int'(ser_out);
            if (done) ndone++;
            if (ndone < 2) cycle();
            if (ndone >= 1) load_valid = 1'b0;
            g++;
        end
        check("b2b_dones", 64'(ndone), 64'(2));
        check("b2b_ones", 64'(ones), 64'(36));

        // Asynchronous reset in the middle of a long transmit.
        wait_dig(34);
        load_valid = 1'b1;
        load_data  = 36'hA_5A5A_5A5A;
        load_long  = 1'b1;
        cycle();
        load_valid = 1'b0;
        wait_dig(20);
        check("busy_before_reset", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'({ser_out, busy, done, load_ready, sync_err}), 64'(5'b00010));
        exp_q.delete();
        cur      = 3'b000;
        exp_sync = 1'b0;
        #2 rst_n = 1'b1;

        for (int i = 3; i < 7; i++) run_vec(i);

        for (int c = 0; c < 1500; c++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = {4'($urandom_range(0, 15)), 32'($urandom())};
            load_long  = 1'($urandom_range(0, 1));
            load_half  = 1'($urandom_range(0, 1));
            cycle();
        end
        load_valid = 1'b0;
        g = 0;
        while ((exp_q.size() > 0 || cur != 3'b000) && g < 200) begin
            cycle();
            g++;
        end
        check("drain_idle", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
